program_counter: RTL and testbench
==================================

Name: program_counter

Overview:
- Architectural program-counter register for the RV32IM five-stage pipeline; sits at the head of the IF stage.
- Holds the fetch address. Loads the next-PC value selected upstream (sequential, branch or jump target) each cycle, unless the hazard unit stalls it with pc_write low.
- Also provides the sequential successor address, pc_out + 4, for the next-PC mux.

Parameters:
- XLEN, 32, width of the PC and all address ports.
- RESET_VECTOR, 32'h0000_0000, value loaded into the PC while reset is asserted.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. Low forces the PC to RESET_VECTOR immediately.
- pc_write  input  1  load enable. 1 = load next_pc at the next rising edge; 0 = stall (hold).
- next_pc  input  XLEN  candidate next fetch address from the next-PC mux.
- pc_out  output  XLEN  current fetch address, registered.
- pc_plus4  output  XLEN  combinational pc_out + 4.
- misaligned  output  1  registered flag: the last attempted load was not word aligned. Driven only when PC_ALIGN_CHECK_EN is defined, otherwise constant 0.

Behaviour:
- Reset is asynchronous and active-low, in a single clock domain.
- While reset = 0: pc_out = RESET_VECTOR and misaligned = 0, regardless of clk, pc_write or next_pc.
- Reset deassertion takes effect at the first rising edge with reset = 1.
- Reset asserted mid-operation overrides any pending load; the PC returns to RESET_VECTOR immediately.
- Rising edge with reset = 1 and pc_write = 1: pc_out <= next_pc. Latency is one cycle; the new value is visible just after the edge.
- Rising edge with reset = 1 and pc_write = 0: pc_out holds its value (stall). Changes on next_pc are ignored.
- No restriction on pc_write toggling; every edge is evaluated independently.
- next_pc equal to pc_out with pc_write = 1 is a legal reload; no visible change.
- pc_plus4 = pc_out + 4, truncated to XLEN bits; wraps modulo 2^XLEN (32'hFFFF_FFFC -> 32'h0000_0000). No carry out.
- No internal combinational path from next_pc to pc_out.
- Without the optional feature, next_pc is stored verbatim, including bits [1:0], and misaligned is tied to 0.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - A rising edge with reset = 1, pc_write = 1 and next_pc[1:0] != 2'b00 does not update the PC; pc_out holds.
  - misaligned is set to 1 for exactly that following cycle.
  - Any other edge (aligned load, or stall) clears misaligned to 0.
  - Aligned loads behave as in Behaviour.
  - Reset clears misaligned.
- Not defined: no alignment checking; misaligned is constant 0; all loads accepted.

Test Plan:
- Reset: hold reset = 0 with pc_write = 1, next_pc = 32'h0000_0004 over several edges -> pc_out stays 32'h0000_0000 and pc_plus4 = 32'h0000_0004.
- Load: release reset, pc_write = 1, next_pc = 32'h0000_0004, one edge -> pc_out = 32'h0000_0004. Then next_pc = 32'h0000_0008, one edge -> pc_out = 32'h0000_0008.
- Stall: pc_write = 0, next_pc = 32'h0000_000C, one edge -> pc_out stays 32'h0000_0008. Then pc_write = 1, one edge -> pc_out = 32'h0000_000C.
- Async reset mid-run: with pc_out = 32'h0000_000C, pull reset low between edges -> pc_out = 32'h0000_0000 before the next edge.
- Wrap: load next_pc = 32'hFFFF_FFFC -> pc_plus4 = 32'h0000_0000.
- Alignment (PC_ALIGN_CHECK_EN defined): with pc_out = 32'h0000_0008, load next_pc = 32'h0000_0006 -> pc_out stays 32'h0000_0008 and misaligned = 1 for one cycle. A following aligned load of 32'h0000_0010 -> pc_out = 32'h0000_0010, misaligned = 0.

Source files
------------

// File: rtl/program_counter.sv
// Fetch-address register at the head of IF, with sequential successor.
// Optional alignment trap on loads enabled by defining PC_ALIGN_CHECK_EN.
module program_counter #(
   parameter int unsigned          XLEN         = 32,
   parameter logic [XLEN-1:0]      RESET_VECTOR = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            pc_write,
   input  logic [XLEN-1:0] next_pc,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] pc_plus4,
   output logic            misaligned
);

   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   logic [XLEN-1:0] r_pc;
   logic            w_load;

`ifdef PC_ALIGN_CHECK_EN
   logic w_aligned;
   logic w_mis_nxt;
   logic r_mis;

   assign w_aligned = (next_pc[1:0] == 2'b00);
   assign w_load    = pc_write & w_aligned;
   // A rejected load flags for one cycle; any other edge clears it.
   assign w_mis_nxt = pc_write & ~w_aligned;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mis <= 1'b0;
      end else begin
         r_mis <= w_mis_nxt;
      end
   end

   assign misaligned = r_mis;
`else
   assign w_load     = pc_write;
   assign misaligned = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc <= RESET_VECTOR;
      end else if (w_load) begin
         r_pc <= next_pc;
      end
   end

   assign pc_out   = r_pc;
   assign pc_plus4 = r_pc + PC_STEP;

endmodule

// File: tb/tb_program_counter.sv
// Bench for program_counter: directed vector table, async-reset sequence,
// and randomized traffic against a simple architectural model.
module tb_program_counter;

   logic        clk;
   logic        reset;
   logic        pc_write;
   logic [31:0] next_pc;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;
   logic        misaligned;

   int n_tests;
   int n_fail;

   program_counter #(
      .XLEN(32),
      .RESET_VECTOR(32'h0000_0000)
   ) dut (
      .clk(clk),
      .reset(reset),
      .pc_write(pc_write),
      .next_pc(next_pc),
      .pc_out(pc_out),
      .pc_plus4(pc_plus4),
      .misaligned(misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        we;
      logic [31:0] npc;
      logic [31:0] pc;
      logic [31:0] p4;
      logic        mis;
   } vec_t;

   vec_t tbl[$];

`ifdef PC_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   // Architectural model state
   longint unsigned m_pc;
   bit              m_mis;

   task automatic chk32(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm,
                       input logic act,
                       input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b want %b", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rst,
                               input logic we,
                               input logic [31:0] npc,
                               input logic [31:0] pc,
                               input logic [31:0] p4,
                               input logic mis);
      vec_t v;
      v.rst = rst;
      v.we  = we;
      v.npc = npc;
      v.pc  = pc;
      v.p4  = p4;
      v.mis = mis;
      return v;
   endfunction

   // One clocked step: drive on negedge, sample 1ns after posedge.
   task automatic step(input logic rst,
                       input logic we,
                       input logic [31:0] npc);
      @(negedge clk);
      reset    = rst;
      pc_write = we;
      next_pc  = npc;
      @(posedge clk);
      #1;
   endtask

   task automatic model_edge(input bit rst,
                             input bit we,
                             input longint unsigned npc);
      if (!rst) begin
         m_pc  = 0;
         m_mis = 0;
      end else if (we && (!ALIGN || (npc % 4) == 0)) begin
         m_pc  = npc;
         m_mis = 0;
      end else if (we) begin
         m_mis = 1;
      end else begin
         m_mis = 0;
      end
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      reset    = 1'b0;
      pc_write = 1'b1;
      next_pc  = 32'h4;

      tbl.push_back(mk(0, 1, 32'h4, 32'h0, 32'h4, 0));
      tbl.push_back(mk(0, 1, 32'h4, 32'h0, 32'h4, 0));
      tbl.push_back(mk(0, 1, 32'h4, 32'h0, 32'h4, 0));
      tbl.push_back(mk(1, 1, 32'h4, 32'h4, 32'h8, 0));
      tbl.push_back(mk(1, 1, 32'h8, 32'h8, 32'hC, 0));
      tbl.push_back(mk(1, 0, 32'hC, 32'h8, 32'hC, 0));
      tbl.push_back(mk(1, 1, 32'hC, 32'hC, 32'h10, 0));
      tbl.push_back(mk(1, 1, 32'hC, 32'hC, 32'h10, 0));
      tbl.push_back(mk(1, 0, 32'h40, 32'hC, 32'h10, 0));
      tbl.push_back(mk(1, 1, 32'hFFFF_FFFC,
                       32'hFFFF_FFFC, 32'h0, 0));
      tbl.push_back(mk(1, 1, 32'h8, 32'h8, 32'hC, 0));
`ifdef PC_ALIGN_CHECK_EN
      tbl.push_back(mk(1, 1, 32'h6, 32'h8, 32'hC, 1));
      tbl.push_back(mk(1, 1, 32'h10, 32'h10, 32'h14, 0));
      tbl.push_back(mk(1, 1, 32'h13, 32'h10, 32'h14, 1));
      tbl.push_back(mk(1, 0, 32'h13, 32'h10, 32'h14, 0));
`else
      tbl.push_back(mk(1, 1, 32'h6, 32'h6, 32'hA, 0));
      tbl.push_back(mk(1, 1, 32'h10, 32'h10, 32'h14, 0));
      tbl.push_back(mk(1, 1, 32'h13, 32'h13, 32'h17, 0));
      tbl.push_back(mk(1, 0, 32'h20, 32'h13, 32'h17, 0));
`endif

      #2;
      chk32("reset_pc", pc_out, 32'h0);
      chk32("reset_p4", pc_plus4, 32'h4);
      chk1("reset_mis", misaligned, 1'b0);

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].we, tbl[i].npc);
         chk32($sformatf("vec%0d_pc", i), pc_out, tbl[i].pc);
         chk32($sformatf("vec%0d_p4", i), pc_plus4, tbl[i].p4);
         chk1($sformatf("vec%0d_mis", i), misaligned, tbl[i].mis);
      end

      // Async reset mid-run: observed before the next rising edge
      step(1, 1, 32'hC);
      chk32("pre_async_pc", pc_out, 32'hC);
      @(negedge clk);
      pc_write = 1'b1;
      next_pc  = 32'h100;
      #1;
      reset = 1'b0;
      #1;
      chk32("async_pc", pc_out, 32'h0);
      chk32("async_p4", pc_plus4, 32'h4);
      chk1("async_mis", misaligned, 1'b0);
      @(posedge clk);
      #1;
      chk32("async_hold_pc", pc_out, 32'h0);

      // Release: first rising edge with reset high loads
      step(1, 1, 32'h200);
      chk32("release_pc", pc_out, 32'h200);

      // Randomized run against the model
      m_pc  = 64'h200;
      m_mis = 0;
      for (int k = 0; k < 300; k++) begin
         bit          r_rst;
         bit          r_we;
         logic [31:0] r_np;
         r_rst = ($urandom_range(0, 15) != 0);
         r_we  = $urandom_range(0, 2) != 0;
         r_np  = $urandom;
         if ($urandom_range(0, 1) == 0) r_np[1:0] = 2'b00;
         if ($urandom_range(0, 9) == 0) r_np = 32'hFFFF_FFFC;
         step(r_rst, r_we, r_np);
         model_edge(r_rst, r_we, longint'(r_np));
         chk32($sformatf("rnd%0d_pc", k), pc_out, m_pc[31:0]);
         chk32($sformatf("rnd%0d_p4", k), pc_plus4,
               32'((m_pc + 4) % 64'h1_0000_0000));
         chk1($sformatf("rnd%0d_mis", k), misaligned, m_mis);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
